// File: rtl/centroid_motor_ctrl_pkg.sv
// Shared definitions for the colour-centroid stage and the motor controller:
// centroid codes, controller state encoding and the centroid decoder.
package centroid_pkg;

    localparam int unsigned c_nb_centroid = 8;
    localparam int unsigned c_nb_prox     = 3;

    localparam logic [c_nb_centroid-1:0] c_code_empty  = 8'h00;
    localparam logic [c_nb_centroid-1:0] c_code_l4     = 8'h01;
    localparam logic [c_nb_centroid-1:0] c_code_l3     = 8'h02;
    localparam logic [c_nb_centroid-1:0] c_code_l2     = 8'h04;
    localparam logic [c_nb_centroid-1:0] c_code_l1     = 8'h08;
    localparam logic [c_nb_centroid-1:0] c_code_center = 8'h18;
    localparam logic [c_nb_centroid-1:0] c_code_r1     = 8'h10;
    localparam logic [c_nb_centroid-1:0] c_code_r2     = 8'h20;
    localparam logic [c_nb_centroid-1:0] c_code_r3     = 8'h40;
    localparam logic [c_nb_centroid-1:0] c_code_r4     = 8'h80;

    typedef enum logic [1:0] {
        st_idle   = 2'd0,
        st_track  = 2'd1,
        st_search = 2'd2,
        st_halt   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        frm_empty,
        frm_valid,
        frm_invalid
    } frame_kind_t;

    // Steering level as side + magnitude; magnitude 0 is the centred code.
    typedef struct packed {
        frame_kind_t kind;
        logic        left;
        logic [2:0]  mag;
    } decode_t;

    function automatic decode_t decode_centroid(input logic [c_nb_centroid-1:0] code);
        decode_t d;
        d.kind = frm_valid;
        d.left = 1'b0;
        d.mag  = 3'd0;
        case (code)
            c_code_l4:     begin d.left = 1'b1; d.mag = 3'd4; end
            c_code_l3:     begin d.left = 1'b1; d.mag = 3'd3; end
            c_code_l2:     begin d.left = 1'b1; d.mag = 3'd2; end
            c_code_l1:     begin d.left = 1'b1; d.mag = 3'd1; end
            c_code_center: d.mag = 3'd0;
            c_code_r1:     d.mag = 3'd1;
            c_code_r2:     d.mag = 3'd2;
            c_code_r3:     d.mag = 3'd3;
            c_code_r4:     d.mag = 3'd4;
            c_code_empty:  d.kind = frm_empty;
            default:       d.kind = frm_invalid;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/centroid_motor_ctrl_if.sv
// Per-frame result bus from the centroid stage into the motor controller.
interface centroid_motor_ctrl_if;
    import centroid_pkg::*;

    logic                     new_centroid_i;
    logic [c_nb_centroid-1:0] centroid_i;
    logic [c_nb_prox-1:0]     proximity_i;

    modport master (output new_centroid_i, centroid_i, proximity_i);
    modport slave  (input  new_centroid_i, centroid_i, proximity_i);
endinterface

// File: rtl/centroid_motor_ctrl_pwm_gen.sv
// Free-running PWM with a shadow duty register reloaded only at the period wrap.
module pwm_gen #(
    parameter int unsigned c_nb_duty = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [c_nb_duty-1:0] duty,
    output logic                 pwm
);

    logic [c_nb_duty-1:0] cnt;
    logic [c_nb_duty-1:0] shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            shadow <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            if (cnt == '1) begin
                shadow <= duty;
            end
        end
    end

    assign pwm = (cnt < shadow);

endmodule

// File: rtl/centroid_motor_ctrl.sv
// Turns per-frame centroid/proximity results into differential-drive duties,
// with lost-target search, a frame watchdog and two PWM outputs.
module centroid_motor_ctrl #(
    parameter int unsigned c_nb_centroid = centroid_pkg::c_nb_centroid,
    parameter int unsigned c_nb_prox     = centroid_pkg::c_nb_prox,
    parameter int unsigned c_nb_duty     = 8,
    parameter int unsigned c_prox_step   = 32,
    parameter int unsigned c_turn_step   = 32,
    parameter int unsigned c_search_duty = 96,
    parameter int unsigned c_lost_frames = 4,
    parameter int unsigned c_wdog_cycles = 5_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    centroid_motor_ctrl_if.slave  frame,
    output logic                  pwm_left_o,
    output logic                  pwm_right_o,
    output logic [c_nb_duty-1:0]  duty_left_o,
    output logic [c_nb_duty-1:0]  duty_right_o,
    output logic [1:0]            state_o,
    output logic                  cmd_valid_o,
    output logic                  code_err_o
);
    import centroid_pkg::*;

    localparam int unsigned c_duty_max = (1 << c_nb_duty) - 1;
    localparam int unsigned c_prox_max = (1 << c_nb_prox) - 1;
    localparam int unsigned lost_w     = $clog2(c_lost_frames + 1);
    localparam int unsigned wdog_w     = $clog2(c_wdog_cycles + 1);
    localparam logic [lost_w-1:0]    c_lost_lim  = lost_w'(c_lost_frames);
    localparam logic [wdog_w-1:0]    c_wdog_last = wdog_w'(c_wdog_cycles - 1);
    localparam logic [c_nb_duty-1:0] c_search    = c_nb_duty'(c_search_duty);

    function automatic logic [c_nb_duty-1:0] clamp_sub(input int unsigned a, input int unsigned b);
        int unsigned r;
        r = (b >= a) ? 0 : a - b;
        if (r > c_duty_max) begin
            r = c_duty_max;
        end
        return r[c_nb_duty-1:0];
    endfunction

    state_t               state, state_nxt;
    logic [c_nb_duty-1:0] duty_l, duty_r, duty_l_nxt, duty_r_nxt;
    logic [lost_w-1:0]    lost, lost_nxt, lost_inc;
    logic                 last_left, last_left_nxt;
    logic                 cmd_nxt, err_nxt;
    logic [wdog_w-1:0]    wdog;
    logic                 wdog_expire;

    logic [c_nb_centroid-1:0] code;
    decode_t                  dec;
    int unsigned              base, turn;
    logic [c_nb_duty-1:0]     trk_l, trk_r, srch_l, srch_r;

    assign code = frame.centroid_i;
    assign dec  = decode_centroid(code);

    always_comb begin
        base  = (c_prox_max - 32'(frame.proximity_i)) * c_prox_step;
        turn  = 32'(dec.mag) * c_turn_step;
        trk_l = clamp_sub(base, 0);
        trk_r = clamp_sub(base, 0);
        if (dec.mag != 3'd0) begin
            if (dec.left) begin
                trk_l = clamp_sub(base, turn);
            end else begin
                trk_r = clamp_sub(base, turn);
            end
        end
    end

    assign srch_l   = last_left ? '0 : c_search;
    assign srch_r   = last_left ? c_search : '0;
    assign lost_inc = (lost == c_lost_lim) ? lost : lost + 1'b1;

    // A frame pulse in the expiry cycle takes priority, so expiry requires no pulse.
    assign wdog_expire = !frame.new_centroid_i && (state != st_halt) && (wdog == c_wdog_last);

    always_comb begin
        state_nxt     = state;
        duty_l_nxt    = duty_l;
        duty_r_nxt    = duty_r;
        lost_nxt      = lost;
        last_left_nxt = last_left;
        cmd_nxt       = 1'b0;
        err_nxt       = 1'b0;
        if (frame.new_centroid_i) begin
            cmd_nxt = 1'b1;
            err_nxt = (dec.kind == frm_invalid);
            if (dec.kind == frm_valid) begin
                state_nxt  = st_track;
                duty_l_nxt = trk_l;
                duty_r_nxt = trk_r;
                lost_nxt   = '0;
                if (dec.mag != 3'd0) begin
                    last_left_nxt = dec.left;
                end
            end else begin
                lost_nxt = lost_inc;
                case (state)
                    st_track: begin
                        if (lost_inc >= c_lost_lim) begin
                            state_nxt  = st_search;
                            duty_l_nxt = srch_l;
                            duty_r_nxt = srch_r;
                        end
                    end
                    st_search: begin
                        duty_l_nxt = srch_l;
                        duty_r_nxt = srch_r;
                    end
                    default: begin
                        state_nxt  = st_idle;
                        duty_l_nxt = '0;
                        duty_r_nxt = '0;
                    end
                endcase
            end
        end else if (wdog_expire) begin
            state_nxt  = st_halt;
            duty_l_nxt = '0;
            duty_r_nxt = '0;
            cmd_nxt    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= st_idle;
            duty_l      <= '0;
            duty_r      <= '0;
            lost        <= '0;
            last_left   <= 1'b0;
            cmd_valid_o <= 1'b0;
            code_err_o  <= 1'b0;
            wdog        <= '0;
        end else begin
            state       <= state_nxt;
            duty_l      <= duty_l_nxt;
            duty_r      <= duty_r_nxt;
            lost        <= lost_nxt;
            last_left   <= last_left_nxt;
            cmd_valid_o <= cmd_nxt;
            code_err_o  <= err_nxt;
            if (frame.new_centroid_i || wdog_expire) begin
                wdog <= '0;
            end else if (wdog != c_wdog_last) begin
                wdog <= wdog + 1'b1;
            end
        end
    end

    assign duty_left_o  = duty_l;
    assign duty_right_o = duty_r;
    assign state_o      = state;

    pwm_gen #(.c_nb_duty(c_nb_duty)) u_pwm_left (
        .clk  (clk),
        .rst  (rst),
        .duty (duty_l),
        .pwm  (pwm_left_o)
    );

    pwm_gen #(.c_nb_duty(c_nb_duty)) u_pwm_right (
        .clk  (clk),
        .rst  (rst),
        .duty (duty_r),
        .pwm  (pwm_right_o)
    );

endmodule

// File: tb/tb_centroid_motor_ctrl.sv
// Self-checking bench for centroid_motor_ctrl: frame scoreboard, PWM period
// model and per-scenario directed checks.
module tb_centroid_motor_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pwm_left_o, pwm_right_o, cmd_valid_o, code_err_o;
    logic [7:0] duty_left_o, duty_right_o;
    logic [1:0] state_o;

    centroid_motor_ctrl_if fr ();

    centroid_motor_ctrl #(.c_wdog_cycles(1000)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame        (fr),
        .pwm_left_o   (pwm_left_o),
        .pwm_right_o  (pwm_right_o),
        .duty_left_o  (duty_left_o),
        .duty_right_o (duty_right_o),
        .state_o      (state_o),
        .cmd_valid_o  (cmd_valid_o),
        .code_err_o   (code_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dl;
        logic [7:0] dr;
        logic [1:0] st;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    int m_state, m_lost, m_dl, m_dr;
    bit m_last_left;

    function automatic void model_reset();
        m_state = 0; m_lost = 0; m_dl = 0; m_dr = 0; m_last_left = 0;
        sb.delete();
    endfunction

    task automatic model_frame(input logic [7:0] c, input logic [2:0] p);
        int   s, base;
        bit   ok, empty;
        exp_t e;
        ok = 1; empty = 0; s = 0;
        case (c)
            8'h01: s = -4;
            8'h02: s = -3;
            8'h04: s = -2;
            8'h08: s = -1;
            8'h18: s = 0;
            8'h10: s = 1;
            8'h20: s = 2;
            8'h40: s = 3;
            8'h80: s = 4;
            8'h00: begin ok = 0; empty = 1; end
            default: ok = 0;
        endcase
        if (ok) begin
            base = (7 - int'(p)) * 32;
            m_dl = base; m_dr = base;
            if (s < 0) begin
                m_dl = base + s * 32; if (m_dl < 0) m_dl = 0;
                m_last_left = 1;
            end else if (s > 0) begin
                m_dr = base - s * 32; if (m_dr < 0) m_dr = 0;
                m_last_left = 0;
            end
            m_state = 1; m_lost = 0;
        end else begin
            if (m_lost < 4) m_lost++;
            if (m_state == 0 || m_state == 3) begin
                m_state = 0; m_dl = 0; m_dr = 0;
            end else if (!(m_state == 1 && m_lost < 4)) begin
                m_state = 2;
                m_dl = m_last_left ? 0 : 96;
                m_dr = m_last_left ? 96 : 0;
            end
        end
        e.dl = 8'(m_dl); e.dr = 8'(m_dr); e.st = 2'(m_state); e.err = !ok && !empty;
        sb.push_back(e);
    endtask

    task automatic model_halt();
        exp_t e;
        m_state = 3; m_dl = 0; m_dr = 0;
        e.dl = 8'd0; e.dr = 8'd0; e.st = 2'd3; e.err = 1'b0;
        sb.push_back(e);
    endtask

    // Scoreboard: every cmd_valid pulse consumes one expected command.
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid_o === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: cmd_valid with l=%0d r=%0d st=%0d, nothing expected",
                             duty_left_o, duty_right_o, state_o);
                end else begin
                    mon_e = sb.pop_front();
                    if ({duty_left_o, duty_right_o, state_o, code_err_o} !== {mon_e.dl, mon_e.dr, mon_e.st, mon_e.err}) begin
                        bad++;
                        $display("FAIL sb_cmd: got l=%0d r=%0d st=%0d err=%b want l=%0d r=%0d st=%0d err=%b",
                                 duty_left_o, duty_right_o, state_o, code_err_o, mon_e.dl, mon_e.dr, mon_e.st, mon_e.err);
                    end
                end
            end else if (code_err_o !== 1'b0) begin
                total++; bad++;
                $display("FAIL code_err_stray: got %b want 0 outside cmd_valid", code_err_o);
            end
        end
    end

    logic [7:0] pc, sh_l, sh_r;
    bit         pwm_chk = 0;
    bit         per_err = 0;

    always @(posedge clk) begin
        if (rst) begin
            pc <= 8'd0; sh_l <= 8'd0; sh_r <= 8'd0;
        end else begin
            pc <= pc + 8'd1;
            if (pc == 8'd255) begin
                sh_l <= duty_left_o;
                sh_r <= duty_right_o;
            end
        end
    end

    // One comparison per PWM period against a counter/shadow reference.
    always @(negedge clk) begin
        if (rst) begin
            per_err = 0;
        end else if (pwm_chk) begin
            if (pwm_left_o !== (pc < sh_l) || pwm_right_o !== (pc < sh_r)) per_err = 1;
            if (pc == 8'd255) begin
                total++;
                if (per_err) begin
                    bad++;
                    $display("FAIL pwm_period: got pwm_l=%b pwm_r=%b want shadow l=%0d r=%0d at cnt=%0d",
                             pwm_left_o, pwm_right_o, sh_l, sh_r, pc);
                end
                per_err = 0;
            end
        end
    end

    task automatic drive_frame(input logic [7:0] c, input logic [2:0] p);
        @(negedge clk);
        fr.new_centroid_i = 1'b1;
        fr.centroid_i     = c;
        fr.proximity_i    = p;
        model_frame(c, p);
    endtask

    task automatic end_frame();
        @(negedge clk);
        fr.new_centroid_i = 1'b0;
        fr.centroid_i     = 8'h00;
        fr.proximity_i    = 3'd0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [2:0] p);
        drive_frame(c, p);
        end_frame();
    endtask

    task automatic count_pwm(output int hl, output int hr);
        hl = 0; hr = 0;
        repeat (256) @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (pwm_left_o === 1'b1) hl++;
            if (pwm_right_o === 1'b1) hr++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({pwm_left_o, pwm_right_o, duty_left_o, duty_right_o, state_o, cmd_valid_o, code_err_o} !== 22'd0) begin
            bad++;
            $display("FAIL reset_hold: got l=%0d r=%0d st=%0d cmd=%b err=%b want all 0",
                     duty_left_o, duty_right_o, state_o, cmd_valid_o, code_err_o);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({pwm_left_o, pwm_right_o, duty_left_o, duty_right_o, state_o, cmd_valid_o} !== 21'd0) begin
            bad++;
            $display("FAIL reset_release: got l=%0d r=%0d st=%0d want 0 0 IDLE", duty_left_o, duty_right_o, state_o);
        end
        pwm_chk = 1;
    endtask

    task automatic test_idle_empty();
        send_frame(8'h00, 3'd0);
        total++;
        if ({state_o, duty_left_o, duty_right_o, cmd_valid_o} !== {2'd0, 8'd0, 8'd0, 1'b1}) begin
            bad++;
            $display("FAIL idle_empty: got st=%0d l=%0d r=%0d cmd=%b want st=0 l=0 r=0 cmd=1",
                     state_o, duty_left_o, duty_right_o, cmd_valid_o);
        end
    endtask

    task automatic test_track_center();
        int hl, hr;
        send_frame(8'h18, 3'd0);
        total++;
        if ({duty_left_o, duty_right_o, state_o} !== {8'd224, 8'd224, 2'd1}) begin
            bad++;
            $display("FAIL center_p0: got l=%0d r=%0d st=%0d want 224 224 1", duty_left_o, duty_right_o, state_o);
        end
        count_pwm(hl, hr);
        total++;
        if (hl != 224 || hr != 224) begin
            bad++;
            $display("FAIL pwm_224: got high l=%0d r=%0d want 224 224", hl, hr);
        end
    endtask

    task automatic test_steer();
        send_frame(8'h02, 3'd2);
        total++;
        if ({duty_left_o, duty_right_o} !== {8'd64, 8'd160}) begin
            bad++;
            $display("FAIL steer_left3: got l=%0d r=%0d want 64 160", duty_left_o, duty_right_o);
        end
        send_frame(8'h80, 3'd5);
        total++;
        if ({duty_left_o, duty_right_o} !== {8'd64, 8'd0}) begin
            bad++;
            $display("FAIL steer_right4_sat: got l=%0d r=%0d want 64 0", duty_left_o, duty_right_o);
        end
    endtask

    task automatic test_too_close();
        int hl, hr;
        send_frame(8'h18, 3'd7);
        total++;
        if ({duty_left_o, duty_right_o, state_o} !== {8'd0, 8'd0, 2'd1}) begin
            bad++;
            $display("FAIL too_close: got l=%0d r=%0d st=%0d want 0 0 1", duty_left_o, duty_right_o, state_o);
        end
        count_pwm(hl, hr);
        total++;
        if (hl != 0 || hr != 0) begin
            bad++;
            $display("FAIL pwm_zero: got high l=%0d r=%0d want 0 0", hl, hr);
        end
    endtask

    task automatic test_lost_search();
        send_frame(8'h04, 3'd0);
        for (int i = 1; i <= 3; i++) begin
            send_frame(8'h00, 3'd0);
            total++;
            if ({duty_left_o, duty_right_o, state_o} !== {8'd160, 8'd224, 2'd1}) begin
                bad++;
                $display("FAIL lost_hold_%0d: got l=%0d r=%0d st=%0d want 160 224 1", i, duty_left_o, duty_right_o, state_o);
            end
        end
        send_frame(8'h00, 3'd0);
        total++;
        if ({duty_left_o, duty_right_o, state_o} !== {8'd0, 8'd96, 2'd2}) begin
            bad++;
            $display("FAIL search_left: got l=%0d r=%0d st=%0d want 0 96 2", duty_left_o, duty_right_o, state_o);
        end
        send_frame(8'h10, 3'd0);
        total++;
        if ({duty_left_o, duty_right_o, state_o} !== {8'd224, 8'd192, 2'd1}) begin
            bad++;
            $display("FAIL search_reacquire: got l=%0d r=%0d st=%0d want 224 192 1", duty_left_o, duty_right_o, state_o);
        end
    endtask

    task automatic test_invalid();
        send_frame(8'h18, 3'd1);
        send_frame(8'h11, 3'd1);
        total++;
        if ({code_err_o, duty_left_o, duty_right_o, state_o} !== {1'b1, 8'd192, 8'd192, 2'd1}) begin
            bad++;
            $display("FAIL invalid_code: got err=%b l=%0d r=%0d st=%0d want 1 192 192 1",
                     code_err_o, duty_left_o, duty_right_o, state_o);
        end
        send_frame(8'h00, 3'd0);
        send_frame(8'h00, 3'd0);
        total++;
        if (state_o !== 2'd1) begin
            bad++;
            $display("FAIL invalid_lost3: got st=%0d want 1", state_o);
        end
        send_frame(8'h00, 3'd0);
        total++;
        if ({duty_left_o, duty_right_o, state_o} !== {8'd96, 8'd0, 2'd2}) begin
            bad++;
            $display("FAIL search_right: got l=%0d r=%0d st=%0d want 96 0 2", duty_left_o, duty_right_o, state_o);
        end
    endtask

    task automatic test_back_to_back();
        drive_frame(8'h01, 3'd0);
        drive_frame(8'h40, 3'd1);
        total++;
        if ({duty_left_o, duty_right_o, cmd_valid_o} !== {8'd96, 8'd224, 1'b1}) begin
            bad++;
            $display("FAIL b2b_first: got l=%0d r=%0d cmd=%b want 96 224 1", duty_left_o, duty_right_o, cmd_valid_o);
        end
        end_frame();
        total++;
        if ({duty_left_o, duty_right_o, cmd_valid_o} !== {8'd192, 8'd96, 1'b1}) begin
            bad++;
            $display("FAIL b2b_second: got l=%0d r=%0d cmd=%b want 192 96 1", duty_left_o, duty_right_o, cmd_valid_o);
        end
    endtask

    task automatic test_watchdog();
        send_frame(8'h18, 3'd0);
        repeat (999) @(negedge clk);
        total++;
        if (state_o === 2'd3 || cmd_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL wdog_early: got st=%0d cmd=%b want not HALT, cmd 0", state_o, cmd_valid_o);
        end
        model_halt();
        @(negedge clk);
        total++;
        if ({state_o, duty_left_o, duty_right_o, cmd_valid_o} !== {2'd3, 8'd0, 8'd0, 1'b1}) begin
            bad++;
            $display("FAIL wdog_halt: got st=%0d l=%0d r=%0d cmd=%b want 3 0 0 1",
                     state_o, duty_left_o, duty_right_o, cmd_valid_o);
        end
        send_frame(8'h08, 3'd0);
        repeat (998) @(negedge clk);
        drive_frame(8'h18, 3'd3);
        end_frame();
        total++;
        if ({state_o, duty_left_o, duty_right_o} !== {2'd1, 8'd128, 8'd128}) begin
            bad++;
            $display("FAIL wdog_pulse_wins: got st=%0d l=%0d r=%0d want 1 128 128", state_o, duty_left_o, duty_right_o);
        end
    endtask

    task automatic test_reset_mid();
        repeat (100) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain_pre_reset: got %0d pending want 0", sb.size());
        end
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        total++;
        if ({pwm_left_o, pwm_right_o, duty_left_o, duty_right_o, state_o, cmd_valid_o, code_err_o} !== 22'd0) begin
            bad++;
            $display("FAIL reset_mid: got pwm=%b%b l=%0d r=%0d st=%0d want all 0",
                     pwm_left_o, pwm_right_o, duty_left_o, duty_right_o, state_o);
        end
        rst = 1'b0;
        send_frame(8'h20, 3'd0);
        total++;
        if ({duty_left_o, duty_right_o, state_o} !== {8'd224, 8'd160, 2'd1}) begin
            bad++;
            $display("FAIL after_reset: got l=%0d r=%0d st=%0d want 224 160 1", duty_left_o, duty_right_o, state_o);
        end
        repeat (300) @(negedge clk);
    endtask

    initial begin
        fr.new_centroid_i = 1'b0;
        fr.centroid_i     = 8'h00;
        fr.proximity_i    = 3'd0;
        model_reset();
        test_reset();
        test_idle_empty();
        test_track_center();
        test_steer();
        test_too_close();
        test_lost_search();
        test_invalid();
        test_back_to_back();
        test_watchdog();
        test_reset_mid();
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
